// File: rtl/tdm_demux4.sv
// tdm_demux4: de-interleaves a 4-slot time-division-multiplexed word stream
// into four registered channel outputs. A sync-qualified beat marks slot 0.
// HUNT waits for sync; LOCK tracks the slot position and flags frame
// completion and misaligned-sync events.
module tdm_demux4 #(
   parameter int unsigned DW = 8
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          i_valid,
   input  logic          i_sync,
   input  logic [DW-1:0] i_data,
   output logic [DW-1:0] o_ch0,
   output logic [DW-1:0] o_ch1,
   output logic [DW-1:0] o_ch2,
   output logic [DW-1:0] o_ch3,
   output logic          o_frame_valid,
   output logic          o_locked,
   output logic          o_err_sync,
   output logic [1:0]    o_slot
);

   localparam int unsigned NCH    = 4;
   localparam int unsigned SLOT_W = 2;

   typedef enum logic {
      HUNT = 1'b0,
      LOCK = 1'b1
   } state_t;

   state_t            state_q, state_d;
   logic [SLOT_W-1:0] slot_q, slot_d;
   logic [DW-1:0]     ch_q [NCH];
   logic [DW-1:0]     ch_d [NCH];
   logic              fv_q, fv_d;
   logic              err_q, err_d;
   logic              locked_q, locked_d;

   // State, slot counter, channel and flag registers; reset wins over any beat.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q  <= HUNT;
         slot_q   <= '0;
         fv_q     <= 1'b0;
         err_q    <= 1'b0;
         locked_q <= 1'b0;
         for (int k = 0; k < NCH; k++) begin
            ch_q[k] <= '0;
         end
      end else begin
         state_q  <= state_d;
         slot_q   <= slot_d;
         fv_q     <= fv_d;
         err_q    <= err_d;
         locked_q <= locked_d;
         for (int k = 0; k < NCH; k++) begin
            ch_q[k] <= ch_d[k];
         end
      end
   end

   // Next-state logic: idle cycles freeze everything; pulses default low.
   always_comb begin
      state_d = state_q;
      slot_d  = slot_q;
      fv_d    = 1'b0;
      err_d   = 1'b0;
      for (int k = 0; k < NCH; k++) begin
         ch_d[k] = ch_q[k];
      end

      if (i_valid) begin
         case (state_q)
            HUNT: begin
               if (i_sync) begin
                  ch_d[0] = i_data;
                  slot_d  = SLOT_W'(1);
                  state_d = LOCK;
               end
            end
            LOCK: begin
               if (i_sync) begin
                  // Sync always restarts the frame; off slot 0 it is a resync error.
                  err_d   = (slot_q != SLOT_W'(0));
                  ch_d[0] = i_data;
                  slot_d  = SLOT_W'(1);
               end else if (slot_q == SLOT_W'(0)) begin
                  // Expected sync missing: drop the beat and go hunting.
                  err_d   = 1'b1;
                  state_d = HUNT;
                  slot_d  = SLOT_W'(0);
               end else begin
                  ch_d[slot_q] = i_data;
                  slot_d       = slot_q + SLOT_W'(1);
                  fv_d         = (slot_q == SLOT_W'(3));
               end
            end
            default: begin
               state_d = HUNT;
               slot_d  = SLOT_W'(0);
            end
         endcase
      end

      locked_d = (state_d == LOCK);
   end

   assign o_ch0         = ch_q[0];
   assign o_ch1         = ch_q[1];
   assign o_ch2         = ch_q[2];
   assign o_ch3         = ch_q[3];
   assign o_frame_valid = fv_q;
   assign o_locked      = locked_q;
   assign o_err_sync    = err_q;
   assign o_slot        = slot_q;

endmodule

// File: tb/tb_tdm_demux4.sv
// tb_tdm_demux4: directed scenarios for tdm_demux4 with a per-cycle frame
// model and hand-computed literal expectations.
module tb_tdm_demux4;

   localparam int unsigned DW = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          valid;
   logic          sync;
   logic [DW-1:0] data;
   logic [DW-1:0] o_ch0, o_ch1, o_ch2, o_ch3;
   logic          o_frame_valid, o_locked, o_err_sync;
   logic [1:0]    o_slot;

   int checks = 0;
   int passes = 0;
   bit en     = 1'b0;

   tdm_demux4 #(.DW(DW)) dut (
      .i_clk         (clk),
      .i_rst         (rst),
      .i_valid       (valid),
      .i_sync        (sync),
      .i_data        (data),
      .o_ch0         (o_ch0),
      .o_ch1         (o_ch1),
      .o_ch2         (o_ch2),
      .o_ch3         (o_ch3),
      .o_frame_valid (o_frame_valid),
      .o_locked      (o_locked),
      .o_err_sync    (o_err_sync),
      .o_slot        (o_slot)
   );

   always #5 clk = ~clk;

   // Behavioural model: position within the frame plus the last word per channel.
   logic [DW-1:0] m_ch [4];
   int            m_pos;
   bit            m_locked, m_fv, m_err;

   always @(posedge clk) begin
      m_fv  = 1'b0;
      m_err = 1'b0;
      if (rst) begin
         for (int k = 0; k < 4; k++) m_ch[k] = '0;
         m_pos    = 0;
         m_locked = 1'b0;
      end else if (valid) begin
         if (sync) begin
            if (m_locked && m_pos != 0) m_err = 1'b1;
            m_ch[0]  = data;
            m_pos    = 1;
            m_locked = 1'b1;
         end else if (m_locked) begin
            if (m_pos == 0) begin
               m_err    = 1'b1;
               m_locked = 1'b0;
            end else begin
               m_ch[m_pos] = data;
               m_fv        = (m_pos == 3);
               m_pos       = (m_pos + 1) % 4;
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   // Per-cycle compare against the model.
   always @(negedge clk) begin
      if (en) begin
         chk("m_ch0", 32'(o_ch0), 32'(m_ch[0]));
         chk("m_ch1", 32'(o_ch1), 32'(m_ch[1]));
         chk("m_ch2", 32'(o_ch2), 32'(m_ch[2]));
         chk("m_ch3", 32'(o_ch3), 32'(m_ch[3]));
         chk("m_fv", 32'(o_frame_valid), 32'(m_fv));
         chk("m_locked", 32'(o_locked), 32'(m_locked));
         chk("m_err", 32'(o_err_sync), 32'(m_err));
         chk("m_slot", 32'(o_slot), 32'(m_pos));
      end
   end

   // Drive one cycle of inputs (called at a falling edge), return at the next falling edge.
   task automatic step(input bit r, input bit v, input bit s, input logic [DW-1:0] d);
      rst   = r;
      valid = v;
      sync  = s;
      data  = d;
      @(negedge clk);
   endtask

   task automatic lit_ch(input string tag, input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic [DW-1:0] c, input logic [DW-1:0] d);
      chk({tag, "_ch0"}, 32'(o_ch0), 32'(a));
      chk({tag, "_ch1"}, 32'(o_ch1), 32'(b));
      chk({tag, "_ch2"}, 32'(o_ch2), 32'(c));
      chk({tag, "_ch3"}, 32'(o_ch3), 32'(d));
   endtask

   task automatic lit_flags(input string tag, input bit fv, input bit lk, input bit er,
                            input logic [1:0] sl);
      chk({tag, "_fv"}, 32'(o_frame_valid), 32'(fv));
      chk({tag, "_locked"}, 32'(o_locked), 32'(lk));
      chk({tag, "_err"}, 32'(o_err_sync), 32'(er));
      chk({tag, "_slot"}, 32'(o_slot), 32'(sl));
   endtask

   initial begin
      rst = 1'b1; valid = 1'b0; sync = 1'b0; data = '0;
      @(negedge clk);
      step(1, 0, 0, 8'h00);
      en = 1'b1;
      lit_ch("rst", 8'h00, 8'h00, 8'h00, 8'h00);
      lit_flags("rst", 0, 0, 0, 2'd0);

      // Clean frame
      step(0, 1, 1, 8'hA1);
      lit_flags("clean_b1", 0, 1, 0, 2'd1);
      step(0, 1, 0, 8'hB2);
      step(0, 1, 0, 8'hC3);
      lit_flags("clean_b3", 0, 1, 0, 2'd3);
      step(0, 1, 0, 8'hD4);
      lit_ch("clean", 8'hA1, 8'hB2, 8'hC3, 8'hD4);
      lit_flags("clean", 1, 1, 0, 2'd0);
      step(0, 0, 0, 8'h00);
      lit_flags("clean_after", 0, 1, 0, 2'd0);

      // Gapped beats; idle cycles carry junk sync/data that must be ignored
      step(1, 0, 0, 8'h00);
      step(0, 1, 1, 8'hA1);
      step(0, 0, 1, 8'h5A);
      lit_flags("gap_idle1", 0, 1, 0, 2'd1);
      step(0, 1, 0, 8'hB2);
      step(0, 0, 0, 8'h77);
      step(0, 0, 1, 8'h88);
      lit_flags("gap_idle2", 0, 1, 0, 2'd2);
      step(0, 1, 0, 8'hC3);
      lit_flags("gap_c3", 0, 1, 0, 2'd3);
      step(0, 0, 0, 8'h00);
      step(0, 1, 0, 8'hD4);
      lit_ch("gap", 8'hA1, 8'hB2, 8'hC3, 8'hD4);
      lit_flags("gap", 1, 1, 0, 2'd0);
      step(0, 0, 0, 8'h00);

      // Hunt discard
      step(1, 0, 0, 8'h00);
      step(0, 1, 0, 8'h11);
      step(0, 1, 0, 8'h22);
      lit_ch("hunt_drop", 8'h00, 8'h00, 8'h00, 8'h00);
      lit_flags("hunt_drop", 0, 0, 0, 2'd0);
      step(0, 1, 1, 8'h33);
      step(0, 1, 0, 8'h44);
      step(0, 1, 0, 8'h55);
      step(0, 1, 0, 8'h66);
      lit_ch("hunt", 8'h33, 8'h44, 8'h55, 8'h66);
      lit_flags("hunt", 1, 1, 0, 2'd0);

      // Misaligned sync on slot 2
      step(1, 0, 0, 8'h00);
      step(0, 1, 1, 8'h01);
      step(0, 1, 0, 8'h02);
      step(0, 1, 1, 8'hEE);
      lit_ch("mis", 8'hEE, 8'h02, 8'h00, 8'h00);
      lit_flags("mis", 0, 1, 1, 2'd1);
      step(0, 1, 0, 8'h12);
      lit_flags("mis_next", 0, 1, 0, 2'd2);
      step(0, 1, 0, 8'h13);
      step(0, 1, 0, 8'h14);
      lit_ch("mis_done", 8'hEE, 8'h12, 8'h13, 8'h14);
      lit_flags("mis_done", 1, 1, 0, 2'd0);

      // Lost sync after two clean frames; second frame's sync lands on slot 0
      step(1, 0, 0, 8'h00);
      step(0, 1, 1, 8'h10);
      step(0, 1, 0, 8'h20);
      step(0, 1, 0, 8'h30);
      step(0, 1, 0, 8'h40);
      step(0, 1, 1, 8'h50);
      lit_flags("resync_ok", 0, 1, 0, 2'd1);
      step(0, 1, 0, 8'h60);
      step(0, 1, 0, 8'h70);
      step(0, 1, 0, 8'h80);
      lit_ch("frame2", 8'h50, 8'h60, 8'h70, 8'h80);
      step(0, 1, 0, 8'h90);
      lit_ch("lost", 8'h50, 8'h60, 8'h70, 8'h80);
      lit_flags("lost", 0, 0, 1, 2'd0);
      step(0, 1, 0, 8'h91);
      lit_flags("lost_hunt", 0, 0, 0, 2'd0);

      // Reset mid-frame with a concurrent beat
      step(1, 0, 0, 8'h00);
      step(0, 1, 1, 8'hA1);
      step(0, 1, 0, 8'hB2);
      step(1, 1, 0, 8'hC3);
      lit_ch("midrst", 8'h00, 8'h00, 8'h00, 8'h00);
      lit_flags("midrst", 0, 0, 0, 2'd0);
      step(0, 1, 0, 8'hC3);
      step(0, 1, 0, 8'hD4);
      lit_ch("midrst_drop", 8'h00, 8'h00, 8'h00, 8'h00);
      lit_flags("midrst_drop", 0, 0, 0, 2'd0);
      step(0, 0, 0, 8'h00);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
